// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Other blocks that sample oscillator outputs can import the settle-time helper.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SETTLE_CYCLES   = SYNC_STAGES_DEF + 1;

  // Settle time must cover every synchroniser flop plus the edge-detect flop.
  function automatic int settle_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/ro_freq_meter_sync_edge_det.sv
// Synchroniser chain for an asynchronous input followed by a rising-edge pulse.
// The pulse is high for one clk cycle per synchronised 0->1 transition.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign edge_pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated edge counter for a selectable free-running oscillator input.
// Latches a saturating count with overflow flag, readable in parallel or serially.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SEL_W       = $clog2(NUM_SRC),
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 12,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [SEL_W-1:0]   sel,
  input  logic [GATE_W-1:0]  gate_len,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  input  logic               shift_en,
  output logic               ser_out
);

  localparam int SETTLE_N = settle_cycles(SYNC_STAGES);
  localparam int TMR_W    = (GATE_W > $clog2(SETTLE_N)) ? GATE_W : $clog2(SETTLE_N);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [GATE_W-1:0]  gate_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [CNT_W:0]     shreg_q;
  logic               edge_pulse;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (src_in[sel_q]),
    .edge_pulse(edge_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (tmr_q == '0) state_d = (gate_q == '0) ? DONE : MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        if (tmr_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One down-counter times both the settle window and the gate window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      gate_q   <= '0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q  <= sel;
            gate_q <= gate_len;
            tmr_q  <= TMR_W'(SETTLE_N - 1);
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
          end
        end
        SETTLE: begin
          if (tmr_q == '0) tmr_q <= TMR_W'(gate_q) - TMR_W'(1);
          else             tmr_q <= tmr_q - TMR_W'(1);
        end
        MEASURE: begin
          if (tmr_q != '0) tmr_q <= tmr_q - TMR_W'(1);
          if (edge_pulse) begin
            if (cnt_q == '1) ovf_q <= 1'b1;
            else             cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done     <= 1'b1;
          count    <= cnt_q;
          overflow <= ovf_q;
        end
        default: begin
        end
      endcase
    end
  end

  // A fresh result load takes priority over a simultaneous shift request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                shreg_q <= '0;
    else if (state_q == DONE)  shreg_q <= {ovf_q, cnt_q};
    else if (shift_en)         shreg_q <= {shreg_q[CNT_W-1:0], 1'b0};
  end

  assign ser_out = shreg_q[CNT_W];

endmodule
